exp_core_driver: RTL and testbench

//  Initiator for the exp core's load/start/output_ready protocol. Takes float32 operands x from an upstream

---
 rtl/exp_core_driver.sv | 200 ++++++++++++++++++++
 tb/tb_exp_core_driver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_core_driver.sv
// exp_core_driver
//   Issues float32 operands to the exp core over its load/start/output_ready
//   handshake and returns the e^x results, in issue order and each with the
//   tag of its operand, on a valid/ready stream.
//
//   Ports
//     CLK, rst                     clock (rising edge), async active-low reset
//     in_valid/in_ready/in_data/in_tag
//                                  operand stream (x, tag)
//     core_load/core_start/core_x  request side toward the core
//     core_in_ready/core_load_ok   core acceptance handshakes
//     core_out_rdy/core_y          1-cycle result pulse from the core
//     res_valid/res_ready/res_data/res_tag
//                                  result stream (FIFO head)
//     busy                         issue in progress or results outstanding
//     err_unexp/err_timeout        sticky protocol error flags
module exp_core_driver #(
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             core_load,
  output logic             core_start,
  output logic [31:0]      core_x,
  input  logic             core_in_ready,
  input  logic             core_load_ok,
  input  logic             core_out_rdy,
  input  logic [31:0]      core_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             err_unexp,
  output logic             err_timeout
);

  localparam int PW = $clog2(RES_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START} state_t;

  state_t state, state_nxt;

  // Holds in_ready low for the first cycle out of reset so every output
  // reads 0 while rst is asserted.
  logic armed;

  logic [CW-1:0] inflight, count;
  logic [CW:0]   occ;
  logic          credit;

  logic accept, issue, ret_ok, pop;

  logic [TAG_W-1:0] tag_mem [RES_DEPTH];
  logic [PW-1:0]    tag_wp, tag_rp;

  logic [31:0]      rd_mem [RES_DEPTH];
  logic [TAG_W-1:0] rt_mem [RES_DEPTH];
  logic [PW-1:0]    res_wp, res_rp;

  logic [TW-1:0] tmo;

  // Results already buffered plus results still owed by the core must fit
  // in the result FIFO, so a core return can never find it full.
  assign occ    = (CW+1)'(inflight) + (CW+1)'(count);
  assign credit = occ < (CW+1)'(RES_DEPTH);

  assign accept = in_valid && in_ready;
  assign issue  = (state == S_START);
  assign ret_ok = core_out_rdy && (inflight != '0);
  assign pop    = res_valid && res_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    core_load  = 1'b0;
    core_start = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = armed && core_in_ready && credit;
        if (in_valid && armed && core_in_ready && credit) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        if (core_load_ok) state_nxt = S_START;
      end
      S_START: begin
        core_start = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand register: stays stable through LOAD until the next accept.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst)        core_x <= '0;
    else if (accept) core_x <= in_data;
  end

  // ---------------------------------------------------------- tag FIFO
  // Pushed at accept, popped at each valid core return. The core answers in
  // order, so the head is always the tag of the oldest started operand.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      tag_wp <= '0;
      tag_rp <= '0;
      for (int i = 0; i < RES_DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (accept) begin
        tag_mem[tag_wp] <= in_tag;
        tag_wp          <= tag_wp + 1'b1;
      end
      if (ret_ok) tag_rp <= tag_rp + 1'b1;
    end
  end

  // ------------------------------------------------------- result FIFO
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      res_wp <= '0;
      res_rp <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        rd_mem[i] <= '0;
        rt_mem[i] <= '0;
      end
    end else begin
      if (ret_ok) begin
        rd_mem[res_wp] <= core_y;
        rt_mem[res_wp] <= tag_mem[tag_rp];
        res_wp         <= res_wp + 1'b1;
      end
      if (pop) res_rp <= res_rp + 1'b1;
    end
  end

  assign res_valid = (count != '0);
  assign res_data  = res_valid ? rd_mem[res_rp] : '0;
  assign res_tag   = res_valid ? rt_mem[res_rp] : '0;

  // ------------------------------------------------------------ counters
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      count    <= '0;
    end else begin
      case ({issue, ret_ok})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({ret_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ------------------------------------------------------------- errors
  // tmo measures the age of the oldest outstanding op: it restarts when a
  // new oldest op appears (first start, or a return that leaves others
  // behind) and saturates at TIMEOUT.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      tmo         <= '0;
      err_unexp   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (issue && inflight == '0)               tmo <= '0;
      else if (ret_ok && inflight > CW'(1))      tmo <= '0;
      else if (inflight != '0 && tmo != TW'(TIMEOUT)) tmo <= tmo + 1'b1;

      if (core_out_rdy && inflight == '0) err_unexp <= 1'b1;
      if (inflight != '0 && tmo == TW'(TIMEOUT)) err_timeout <= 1'b1;
    end
  end

  assign busy = (state != S_IDLE) || (inflight != '0);

endmodule

// File: tb/tb_exp_core_driver.sv
module tb_exp_core_driver;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int TIMEOUT   = 255;

  logic             CLK = 1'b0, rst = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [31:0]      in_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             core_load, core_start;
  logic [31:0]      core_x;
  logic             core_in_ready = 1'b1, core_load_ok = 1'b0;
  logic             core_out_rdy = 1'b0;
  logic [31:0]      core_y = '0;
  logic             res_valid, res_ready = 1'b1;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy, err_unexp, err_timeout;

  always #5 CLK = ~CLK;

  exp_core_driver #(.RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .core_load(core_load), .core_start(core_start), .core_x(core_x),
    .core_in_ready(core_in_ready), .core_load_ok(core_load_ok),
    .core_out_rdy(core_out_rdy), .core_y(core_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .err_unexp(err_unexp), .err_timeout(err_timeout)
  );

  typedef struct { logic [31:0] d; logic [TAG_W-1:0] t; } res_t;

  res_t        exp_q[$];   // expected results, in operand acceptance order
  logic [31:0] pend_q[$];  // operands the core model has been started on

  int errors = 0, checks = 0, cyc = 0;
  int start_cnt = 0, last_ok = -10;
  bit prev_start = 0;

  // Core model controls
  bit load_auto = 1, out_auto = 1, fire_on_start = 0, inject = 0;
  bit rand_rr = 0, rand_cir = 0, rr_level = 1;

  // Stand-in for the core's e^x: any fixed map works for a pass-through
  // driver; x=0 gives 1.0f.
  function automatic logic [31:0] core_fn(input logic [31:0] x);
    return x + 32'h3F80_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin @(posedge CLK); cyc++; end

  // Core load handshake: random stall before load_ok.
  initial forever begin
    @(posedge CLK); #1;
    core_load_ok = 1'b0;
    if (rst && load_auto && core_load && $urandom_range(0, 2) == 0) core_load_ok = 1'b1;
  end

  // Core result side: in-order returns after random latency, optionally
  // timed to coincide with a core_start.
  initial forever begin
    @(posedge CLK); #1;
    core_out_rdy = 1'b0;
    if (inject) begin
      core_out_rdy = 1'b1;
      core_y       = 32'hDEAD_BEEF;
      inject       = 0;
    end else if (rst && pend_q.size() > 0 &&
                 ((fire_on_start && core_start) || (out_auto && $urandom_range(0, 3) == 0))) begin
      core_out_rdy = 1'b1;
      core_y       = core_fn(pend_q.pop_front());
    end
  end

  // Downstream ready and core_in_ready
  initial forever begin
    @(posedge CLK); #1;
    res_ready     = rand_rr ? 1'($urandom_range(0, 1)) : rr_level;
    core_in_ready = rand_cir ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: start protocol and result scoreboard.
  initial begin
    res_t e;
    forever begin
      @(negedge CLK);
      if (rst) begin
        if (core_load && core_load_ok) last_ok = cyc;
        if (core_start) begin
          start_cnt++;
          pend_q.push_back(core_x);
          chk("start_after_load_ok", cyc, last_ok + 1);
          chk("start_single_pulse", 32'(prev_start), 0);
        end
        prev_start = core_start;
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL res_unexpected: got tag %0d data %h expected no result", res_tag, res_data);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.d);
            chk("res_tag", 32'(res_tag), 32'(e.t));
          end
        end
      end else begin
        prev_start = 0;
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [TAG_W-1:0] t);
    bit acc = 0;
    @(posedge CLK); #1;
    in_valid = 1'b1; in_data = x; in_tag = t;
    for (int i = 0; i < 3000 && !acc; i++) begin
      @(negedge CLK); acc = in_ready;
      @(posedge CLK);
    end
    #1 in_valid = 1'b0;
    if (acc) exp_q.push_back('{core_fn(x), t});
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept for tag %0d expected accept", t);
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge CLK);
      done = (exp_q.size() == 0) && (pend_q.size() == 0) && !busy && !res_valid;
    end
    chk(name, 32'(done), 1);
  endtask

  task automatic wait_load(input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK); seen = core_load;
    end
    chk(name, 32'(seen), 1);
  endtask

  initial begin
    int s0;
    logic [31:0] hold_x;
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    logic [31:0] hold_x;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_core_load", 32'(core_load), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_x", core_x, 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err_unexp", 32'(err_unexp), 0);
    chk("rst_err_timeout", 32'(err_timeout), 0);
    #2 rst = 1'b1;

    // Single op
    send(32'h0000_0000, 4'd3);
    wait_drain("single_drain");

    // Credit gating with a stalled downstream
    rr_level = 0;
    repeat (2) @(posedge CLK);
    s0 = start_cnt;
    fork
      for (int i = 0; i < 6; i++) send($urandom, TAG_W'(i));
    join_none
    repeat (150) @(posedge CLK);
    @(negedge CLK);
    chk("credit_starts", start_cnt - s0, 4);
    chk("credit_in_ready", 32'(in_ready), 0);
    chk("credit_res_valid", 32'(res_valid), 1);
    chk("credit_head_tag", 32'(res_tag), 0);
    rr_level = 1;
    wait fork;
    wait_drain("credit_drain");

    // Load stall
    load_auto = 0;
    fork send($urandom, 4'h9); join_none
    wait_load("stall_load_seen");
    hold_x = core_x;
    s0 = start_cnt;
    repeat (20) begin
      @(negedge CLK);
      chk("stall_core_load", 32'(core_load), 1);
      chk("stall_core_x", core_x, hold_x);
    end
    chk("stall_no_start", start_cnt, s0);
    load_auto = 1;
    wait fork;
    wait_drain("stall_drain");

    // Random traffic with returns forced onto start cycles and random pops
    rand_rr = 1; rand_cir = 1; fire_on_start = 1;
    for (int i = 0; i < 40; i++) send($urandom, TAG_W'($urandom));
    rand_rr = 0; rand_cir = 0; fire_on_start = 0; rr_level = 1;
    wait_drain("random_drain");

    // Unexpected return
    @(negedge CLK);
    chk("pre_err_unexp", 32'(err_unexp), 0);
    inject = 1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("err_unexp_set", 32'(err_unexp), 1);
    chk("unexp_dropped", 32'(res_valid), 0);
    chk("unexp_busy", 32'(busy), 0);
    chk("unexp_no_timeout", 32'(err_timeout), 0);

    // Timeout
    out_auto = 0;
    send(32'h1234_5678, 4'd5);
    repeat (200) @(posedge CLK);
    @(negedge CLK);
    chk("timeout_early", 32'(err_timeout), 0);
    repeat (100) @(posedge CLK);
    @(negedge CLK);
    chk("timeout_set", 32'(err_timeout), 1);
    chk("timeout_busy", 32'(busy), 1);
    out_auto = 1;
    wait_drain("timeout_drain");
    chk("timeout_sticky", 32'(err_timeout), 1);

    // Async reset during LOAD
    load_auto = 0;
    fork send(32'h4000_0000, 4'd7); join_none
    wait_load("rst_mid_load_seen");
    @(posedge CLK); #3 rst = 1'b0;
    #1;
    chk("arst_core_load", 32'(core_load), 0);
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_err_unexp", 32'(err_unexp), 0);
    chk("arst_err_timeout", 32'(err_timeout), 0);
    exp_q.delete();
    pend_q.delete();
    wait fork;
    load_auto = 1;
    @(posedge CLK); #3 rst = 1'b1;
    send(32'h0000_0000, 4'd3);
    wait_drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
